// File: rtl/seq_chunk_adder.sv
// seq_chunk_adder: multi-cycle adder that processes CHUNK bits per clock.
// The LSB chunk goes first, and the carry ripples through a register
// between cycles. Intermediate chunks collect in a shadow register, so
// sum/cout/ovf change only on the edge that enters DONE.
// Optional feature macro: SEQ_ADD_SUB_EN adds the sub port, which selects
// a-b (b is inverted and the carry-in is forced to 1).
module seq_chunk_adder #(
  parameter int WIDTH = 16,
  parameter int CHUNK = 4
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
`ifdef SEQ_ADD_SUB_EN
  input  logic             sub,
`endif
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf
);

  localparam int N     = WIDTH / CHUNK;
  localparam int IDX_W = (N > 1) ? $clog2(N) : 1;
  localparam int SLOTS = 1 << IDX_W;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N - 1);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t state_reg;
  state_t state_next;
  logic   accept;

  logic [WIDTH-1:0] a_reg;
  logic [WIDTH-1:0] b_reg;
  logic [WIDTH-1:0] shadow_reg;
  logic [WIDTH-1:0] shadow_next;
  logic             carry_reg;
  logic [IDX_W-1:0] idx_reg;

  logic [CHUNK-1:0] a_chunk [SLOTS];
  logic [CHUNK-1:0] b_chunk [SLOTS];
  logic [CHUNK-1:0] a_cur;
  logic [CHUNK-1:0] b_cur;
  logic [CHUNK:0]   chunk_total;
  logic             msb_carry_in;
  logic             last_chunk;

  // The latched operands are split into chunk slots. Slots past N-1 are
  // tied to zero so that the index width never over-addresses the array.
  genvar gi;
  generate
    for (gi = 0; gi < SLOTS; gi++) begin : g_slot
      if (gi < N) begin : g_live
        assign a_chunk[gi] = a_reg[gi*CHUNK +: CHUNK];
        assign b_chunk[gi] = b_reg[gi*CHUNK +: CHUNK];
      end else begin : g_pad
        assign a_chunk[gi] = '0;
        assign b_chunk[gi] = '0;
      end
    end
  endgenerate

  // Add the current chunk and the rippled carry. The bit-level carry into
  // the chunk MSB is recovered from the sum bit and feeds the ovf flag.
  always_comb begin
    a_cur        = a_chunk[idx_reg];
    b_cur        = b_chunk[idx_reg];
    chunk_total  = {1'b0, a_cur} + {1'b0, b_cur} + {{CHUNK{1'b0}}, carry_reg};
    msb_carry_in = a_cur[CHUNK-1] ^ b_cur[CHUNK-1] ^ chunk_total[CHUNK-1];
    last_chunk   = (idx_reg == LAST_IDX);
  end

  // Merge the freshly computed chunk into the shadow image of the sum.
  generate
    for (gi = 0; gi < N; gi++) begin : g_merge
      assign shadow_next[gi*CHUNK +: CHUNK] =
        (idx_reg == IDX_W'(gi)) ? chunk_total[CHUNK-1:0]
                                : shadow_reg[gi*CHUNK +: CHUNK];
    end
  endgenerate

  // State register; reset takes priority over everything else.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  // Next-state and handshake outputs. A start is accepted whenever no
  // operation is in flight, which includes DONE for back-to-back work.
  always_comb begin
    state_next = state_reg;
    accept     = 1'b0;
    busy       = 1'b0;
    done       = 1'b0;
    case (state_reg)
      IDLE: begin
        if (start) begin
          accept     = 1'b1;
          state_next = RUN;
        end
      end
      RUN: begin
        busy = 1'b1;
        if (last_chunk) begin
          state_next = DONE;
        end
      end
      DONE: begin
        done = 1'b1;
        if (start) begin
          accept     = 1'b1;
          state_next = RUN;
        end else begin
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // Datapath: latch operands on accept, then compute one chunk per RUN
  // cycle. The visible result is published only with the final chunk.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      a_reg      <= '0;
      b_reg      <= '0;
      shadow_reg <= '0;
      carry_reg  <= 1'b0;
      idx_reg    <= '0;
      sum        <= '0;
      cout       <= 1'b0;
      ovf        <= 1'b0;
    end else if (accept) begin
      a_reg   <= a;
      idx_reg <= '0;
`ifdef SEQ_ADD_SUB_EN
      b_reg     <= sub ? ~b : b;
      carry_reg <= sub ? 1'b1 : cin;
`else
      b_reg     <= b;
      carry_reg <= cin;
`endif
    end else if (state_reg == RUN) begin
      shadow_reg <= shadow_next;
      carry_reg  <= chunk_total[CHUNK];
      idx_reg    <= idx_reg + IDX_W'(1);
      if (last_chunk) begin
        sum  <= shadow_next;
        cout <= chunk_total[CHUNK];
        ovf  <= msb_carry_in ^ chunk_total[CHUNK];
      end
    end
  end

endmodule

// File: tb/tb_seq_chunk_adder.sv
// Scoreboard bench for seq_chunk_adder. Drivers push expected results
// (with the cycle on which done must appear) and monitors pop and compare
// them whenever done is seen. Sub tests run only with SEQ_ADD_SUB_EN.
module tb_seq_chunk_adder;

  typedef struct {
    logic [15:0] sum;
    logic        cout;
    logic        ovf;
    int          cyc;
    int          id;
  } exp_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int errors = 0;

  // 16-bit, 4-bit chunk instance
  logic        reset_n16, start16, cin16;
  logic [15:0] a16, b16, sum16;
  logic        busy16, done16, cout16, ovf16;
`ifdef SEQ_ADD_SUB_EN
  logic        sub16;
`endif

  seq_chunk_adder #(.WIDTH(16), .CHUNK(4)) dut16 (
    .clk(clk), .reset_n(reset_n16), .start(start16), .a(a16), .b(b16),
    .cin(cin16),
`ifdef SEQ_ADD_SUB_EN
    .sub(sub16),
`endif
    .busy(busy16), .done(done16), .sum(sum16), .cout(cout16), .ovf(ovf16)
  );

  // 8-bit, 1-bit chunk instance
  logic        reset_n8, start8, cin8;
  logic [7:0]  a8, b8, sum8;
  logic        busy8, done8, cout8, ovf8;
`ifdef SEQ_ADD_SUB_EN
  logic        sub8;
`endif

  seq_chunk_adder #(.WIDTH(8), .CHUNK(1)) dut8 (
    .clk(clk), .reset_n(reset_n8), .start(start8), .a(a8), .b(b8),
    .cin(cin8),
`ifdef SEQ_ADD_SUB_EN
    .sub(sub8),
`endif
    .busy(busy8), .done(done8), .sum(sum8), .cout(cout8), .ovf(ovf8)
  );

  exp_t q16[$];
  exp_t q8[$];
  exp_t e16;
  exp_t e8;

  // Monitor for the 16-bit instance.
  always @(negedge clk) begin
    if (done16) begin
      checks++;
      if (q16.size() == 0) begin
        errors++;
        $display("FAIL dut16_unexpected_done cyc=%0d sum=%h", cyc, sum16);
      end else begin
        e16 = q16.pop_front();
        if (sum16 !== e16.sum || cout16 !== e16.cout || ovf16 !== e16.ovf ||
            busy16 !== 1'b0 || cyc != e16.cyc) begin
          errors++;
          $display("FAIL dut16_txn%0d got sum=%h cout=%b ovf=%b busy=%b cyc=%0d want sum=%h cout=%b ovf=%b busy=0 cyc=%0d",
                   e16.id, sum16, cout16, ovf16, busy16, cyc, e16.sum, e16.cout, e16.ovf, e16.cyc);
        end else begin
          $display("PASS dut16_txn%0d sum=%h cout=%b ovf=%b cyc=%0d",
                   e16.id, sum16, cout16, ovf16, cyc);
        end
      end
    end
  end

  // Monitor for the 8-bit instance.
  always @(negedge clk) begin
    if (done8) begin
      checks++;
      if (q8.size() == 0) begin
        errors++;
        $display("FAIL dut8_unexpected_done cyc=%0d sum=%h", cyc, sum8);
      end else begin
        e8 = q8.pop_front();
        if ({8'h00, sum8} !== e8.sum || cout8 !== e8.cout || ovf8 !== e8.ovf ||
            busy8 !== 1'b0 || cyc != e8.cyc) begin
          errors++;
          $display("FAIL dut8_txn%0d got sum=%h cout=%b ovf=%b busy=%b cyc=%0d want sum=%h cout=%b ovf=%b busy=0 cyc=%0d",
                   e8.id, sum8, cout8, ovf8, busy8, cyc, e8.sum[7:0], e8.cout, e8.ovf, e8.cyc);
        end else begin
          $display("PASS dut8_txn%0d sum=%h cout=%b ovf=%b cyc=%0d",
                   e8.id, sum8, cout8, ovf8, cyc);
        end
      end
    end
  end

  task automatic chk(input string name, input logic [15:0] got, input logic [15:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s got=%h want=%h", name, got, want);
    end
  endtask

  // Issue one 16-bit operation from a negedge, check busy on each edge
  // from T through T+4, and return one negedge after the done cycle.
  // With glitch set, start is re-pulsed (a=b=1) for edge T+2.
  task automatic go16(input logic [15:0] ta, input logic [15:0] tb_v, input logic tc,
                      input logic [15:0] es, input logic ec, input logic eo,
                      input int id, input bit glitch);
    a16 = ta; b16 = tb_v; cin16 = tc; start16 = 1'b1;
    q16.push_back(exp_t'{es, ec, eo, cyc + 1 + 4, id});
    for (int k = 0; k <= 4; k++) begin
      @(negedge clk);
      if (k == 0) start16 = 1'b0;
      if (glitch && k == 1) begin
        a16 = 16'h0001; b16 = 16'h0001; start16 = 1'b1;
      end
      if (glitch && k == 2) start16 = 1'b0;
      chk($sformatf("busy16_txn%0d_edge%0d", id, k), {15'd0, busy16}, {15'd0, k < 4});
    end
    @(negedge clk);
  endtask

  task automatic go8(input logic [7:0] ta, input logic [7:0] tb_v, input logic tc,
                     input logic [7:0] es, input logic ec, input logic eo, input int id);
    a8 = ta; b8 = tb_v; cin8 = tc; start8 = 1'b1;
    q8.push_back(exp_t'{{8'h00, es}, ec, eo, cyc + 1 + 8, id});
    for (int k = 0; k <= 8; k++) begin
      @(negedge clk);
      if (k == 0) start8 = 1'b0;
      chk($sformatf("busy8_txn%0d_edge%0d", id, k), {15'd0, busy8}, {15'd0, k < 8});
    end
    @(negedge clk);
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog_timeout cyc=%0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    reset_n16 = 1'b0; start16 = 1'b0; a16 = '0; b16 = '0; cin16 = 1'b0;
    reset_n8  = 1'b0; start8  = 1'b0; a8  = '0; b8  = '0; cin8  = 1'b0;
`ifdef SEQ_ADD_SUB_EN
    sub16 = 1'b0; sub8 = 1'b0;
`endif
    repeat (3) @(negedge clk);
    chk("reset_busy", {15'd0, busy16}, 16'd0);
    chk("reset_done", {15'd0, done16}, 16'd0);
    chk("reset_sum", sum16, 16'h0000);
    chk("reset_cout", {15'd0, cout16}, 16'd0);
    chk("reset_ovf", {15'd0, ovf16}, 16'd0);
    reset_n16 = 1'b1; reset_n8 = 1'b1;
    @(negedge clk);

    go16(16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b1, 1'b0, 1, 1'b0);
    go16(16'h1234, 16'h4321, 1'b1, 16'h5556, 1'b0, 1'b0, 2, 1'b0);
    go16(16'h7FFF, 16'h0001, 1'b0, 16'h8000, 1'b0, 1'b1, 3, 1'b0);
    go16(16'h0F0F, 16'h00F1, 1'b0, 16'h1000, 1'b0, 1'b0, 4, 1'b1);
    repeat (3) @(negedge clk);
    chk("hold_sum_idle", sum16, 16'h1000);

    // Abort an operation with reset on edge T+2.
    a16 = 16'h00FF; b16 = 16'h0001; cin16 = 1'b0; start16 = 1'b1;
    @(negedge clk); start16 = 1'b0;
    @(negedge clk); reset_n16 = 1'b0;
    @(negedge clk); reset_n16 = 1'b1;
    chk("abort_busy", {15'd0, busy16}, 16'd0);
    chk("abort_done", {15'd0, done16}, 16'd0);
    chk("abort_sum", sum16, 16'h0000);
    chk("abort_cout", {15'd0, cout16}, 16'd0);
    chk("abort_ovf", {15'd0, ovf16}, 16'd0);
    repeat (8) @(negedge clk);
    chk("abort_still_idle", {15'd0, busy16}, 16'd0);
    go16(16'h0001, 16'h0002, 1'b1, 16'h0004, 1'b0, 1'b0, 5, 1'b0);

    // Start held high: results at T+4, T+9, T+14.
    a16 = 16'h8000; b16 = 16'h8000; cin16 = 1'b0; start16 = 1'b1;
    q16.push_back(exp_t'{16'h0000, 1'b1, 1'b1, cyc + 1 + 4, 6});
    q16.push_back(exp_t'{16'h0000, 1'b1, 1'b1, cyc + 1 + 9, 7});
    q16.push_back(exp_t'{16'h0000, 1'b1, 1'b1, cyc + 1 + 14, 8});
    repeat (15) @(negedge clk);
    start16 = 1'b0;
    repeat (3) @(negedge clk);

`ifdef SEQ_ADD_SUB_EN
    sub16 = 1'b1;
    go16(16'h0005, 16'h0007, 1'b0, 16'hFFFE, 1'b0, 1'b0, 9, 1'b0);
    go16(16'h8000, 16'h0001, 1'b0, 16'h7FFF, 1'b1, 1'b1, 10, 1'b0);
    sub16 = 1'b0;
`endif

    go8(8'hAA, 8'h55, 1'b1, 8'h00, 1'b1, 1'b0, 11);
    go8(8'h7F, 8'h01, 1'b0, 8'h80, 1'b0, 1'b1, 12);

    repeat (4) @(negedge clk);
    chk("q16_drained", 16'(q16.size()), 16'd0);
    chk("q8_drained", 16'(q8.size()), 16'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
